regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Sole writer of the 16x19-bit register file write port (rd/write_data/regwrite).
//  - Merges single-cycle ALU results with in-order multi-cycle load responses.
//  - Tracks outstanding load destinations in a tag FIFO.
//  - Exports a per-register scoreboard so decode can stall on RAW hazards against pending loads.
// PARAMETERS
//  DATA_W    19  register/data width
//  ADDR_W    4   register index width (2**ADDR_W registers, x0 hardwired zero)
//  LQ_DEPTH  2   max outstanding loads (tag FIFO depth, power of 2, >=2)
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-high reset
//  alu_valid      in   1       ALU result valid this cycle (cannot be stalled)
//  alu_rd         in   ADDR_W  ALU destination
//  alu_data       in   DATA_W  ALU result
//  ld_issue       in   1       decode issues a load this cycle
//  ld_issue_rd    in   ADDR_W  load destination
//  issue_stall    out  1       tag FIFO full; decode must not assert ld_issue
//  ld_resp_valid  in   1       memory load data valid
//  ld_resp_ready  out  1       writeback accepts load data
//  ld_resp_data   in   DATA_W  load data (responses return in issue order)
//  sb_rs1         in   ADDR_W  scoreboard query 1
//  sb_rs2         in   ADDR_W  scoreboard query 2
//  sb_busy1       out  1       sb_rs1 has a pending write
//  sb_busy2       out  1       sb_rs2 has a pending write
//  rd             out  ADDR_W  register file write address (registered)
//  write_data     out  DATA_W  register file write data (registered)
//  regwrite       out  1       register file write enable (registered)
//  err_overflow   out  1       sticky: ld_issue seen while full and not popping
// BEHAVIOUR
//  - Reset (async): rd=0, write_data=0, regwrite=0, err_overflow=0, FIFO empty, all pending counters 0.
//  - Reset mid-operation discards every in-flight load. Post-reset responses see an empty FIFO and are not accepted.
//  - Arbitration: ALU has absolute priority.
//    - ld_resp_ready = !alu_valid && !fifo_empty (combinational).
//    - Load handshake = ld_resp_valid && ld_resp_ready.
//  - Write port registered, latency 1: the source accepted at edge N drives rd/write_data/regwrite during cycle N..N+1; the register file captures at edge N+1.
//    - No source accepted -> regwrite=0; rd/write_data hold their previous values.
//    - Destination 0 -> regwrite=0 (the tag is still popped for a load).
//  - Tag FIFO:
//    - Push ld_issue_rd on ld_issue.
//    - Pop head on load handshake; head is the rd for that response.
//    - Push and pop in the same cycle are both performed; count unchanged, legal even when full.
//    - ld_issue while full without a pop: push dropped, err_overflow set until reset.
//    - issue_stall = fifo_full (combinational).
//  - Scoreboard: per-register counter, width clog2(LQ_DEPTH+1).
//    - +1 on accepted push (rd!=0); -1 on load handshake for the popped rd.
//    - Same rd in the same cycle -> net 0.
//  - busyN = (cnt[sb_rsN]!=0) || (regwrite && rd==sb_rsN && sb_rsN!=0); covers the write-port cycle before register file capture.
//  - sb_rsN==0 never busy.
//  - ALU write to a register with a pending load: the write proceeds; the later load overwrites it. WAW avoidance is the decoder's duty via sb_busy.
// TESTING
//  1. alu_valid=1, rd=5, data=19'h1ABCD -> next cycle regwrite=1, rd=5, write_data=19'h1ABCD; regwrite=0 the cycle after.
//  2. ld_issue rd=3 -> sb_busy1(rs1=3)=1. Resp 19'h00042 two cycles later -> write rd=3 issued the next cycle; busy drops one cycle after regwrite pulse.
//  3. Issue loads rd=1 then rd=2 (FIFO full, issue_stall=1) -> responses A,B write rd=1<-A then rd=2<-B in order; stall clears on first pop.
//  4. Load resp valid with alu_valid=1 same cycle -> ld_resp_ready=0, ALU written first, load written the following cycle.
//  5. Third ld_issue while full, no pop -> err_overflow=1 sticky, FIFO count stays 2; a push coinciding with a pop is accepted with no error.
//  6. Assert reset with 2 loads pending -> all outputs 0, busy=0, ld_resp_ready=0; ALU rd=0 write afterwards -> regwrite stays 0.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: ALU, load-issue, load-response, scoreboard and register-file write bundle
interface regfile_writeback_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 4
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_issue_rd;
    logic              issue_stall;
    logic              ld_resp_valid;
    logic              ld_resp_ready;
    logic [DATA_W-1:0] ld_resp_data;
    logic [ADDR_W-1:0] sb_rs1;
    logic [ADDR_W-1:0] sb_rs2;
    logic              sb_busy1;
    logic              sb_busy2;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] write_data;
    logic              regwrite;
    logic              err_overflow;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
               ld_resp_valid, ld_resp_data, sb_rs1, sb_rs2,
        input  issue_stall, ld_resp_ready, sb_busy1, sb_busy2,
               rd, write_data, regwrite, err_overflow
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
               ld_resp_valid, ld_resp_data, sb_rs1, sb_rs2,
        output issue_stall, ld_resp_ready, sb_busy1, sb_busy2,
               rd, write_data, regwrite, err_overflow
    );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: sole register-file writer merging ALU results with in-order load responses
module regfile_writeback #(
    parameter int DATA_W   = 19,
    parameter int ADDR_W   = 4,
    parameter int LQ_DEPTH = 2
) (
    input logic clk,
    input logic reset,
    regfile_writeback_if.slave bus
);
    localparam int NREG = 2**ADDR_W;
    localparam int PW   = $clog2(LQ_DEPTH);
    localparam int CW   = $clog2(LQ_DEPTH + 1);

    logic [ADDR_W-1:0] tags [LQ_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     cnt [NREG];
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] head;

    assign fifo_empty        = count == '0;
    assign fifo_full         = count == CW'(LQ_DEPTH);
    assign head              = tags[rd_ptr];
    assign bus.ld_resp_ready = !bus.alu_valid && !fifo_empty;
    assign bus.issue_stall   = fifo_full;
    assign pop               = bus.ld_resp_valid && bus.ld_resp_ready;
    // a pop frees the slot this same cycle, so a push while full is legal then
    assign push              = bus.ld_issue && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push)
            tags[wr_ptr] <= bus.ld_issue_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            bus.err_overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push) - CW'(pop);
            if (bus.ld_issue && fifo_full && !pop)
                bus.err_overflow <= 1'b1;
        end
    end

    // cnt[0] stays zero: x0 is never a pending destination
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++)
                cnt[i] <= cnt[i] + CW'(push && bus.ld_issue_rd == ADDR_W'(i))
                                 - CW'(pop && head == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rd         <= '0;
            bus.write_data <= '0;
            bus.regwrite   <= 1'b0;
        end else if (bus.alu_valid) begin
            bus.rd         <= bus.alu_rd;
            bus.write_data <= bus.alu_data;
            bus.regwrite   <= bus.alu_rd != '0;
        end else if (pop) begin
            bus.rd         <= head;
            bus.write_data <= bus.ld_resp_data;
            bus.regwrite   <= head != '0;
        end else begin
            bus.regwrite   <= 1'b0;
        end
    end

    // the write-port term covers the cycle before the register file captures
    assign bus.sb_busy1 = bus.sb_rs1 != '0 &&
                          (cnt[bus.sb_rs1] != '0 || (bus.regwrite && bus.rd == bus.sb_rs1));
    assign bus.sb_busy2 = bus.sb_rs2 != '0 &&
                          (cnt[bus.sb_rs2] != '0 || (bus.regwrite && bus.rd == bus.sb_rs2));
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized writeback traffic checked against a queue-based reference model
module tb_regfile_writeback;
    localparam int DATA_W = 19;
    localparam int ADDR_W = 4;
    localparam int LQ     = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LQ_DEPTH(LQ)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass = 0;
    int q[$];
    int exp_rd = 0;
    int exp_wd = 0;
    bit exp_rw = 1'b0;
    bit exp_err = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit busy_of(input int r);
        if (r == 0)
            return 1'b0;
        foreach (q[i])
            if (q[i] == r)
                return 1'b1;
        return exp_rw && exp_rd == r;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_rd = 0;
        exp_wd = 0;
        exp_rw = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic check_all();
        check("issue_stall", int'(bus.issue_stall), int'(q.size() == LQ));
        check("ld_resp_ready", int'(bus.ld_resp_ready), int'(!bus.alu_valid && q.size() != 0));
        check("sb_busy1", int'(bus.sb_busy1), int'(busy_of(int'(bus.sb_rs1))));
        check("sb_busy2", int'(bus.sb_busy2), int'(busy_of(int'(bus.sb_rs2))));
        check("rd", int'(bus.rd), exp_rd);
        check("write_data", int'(bus.write_data), exp_wd);
        check("regwrite", int'(bus.regwrite), int'(exp_rw));
        check("err_overflow", int'(bus.err_overflow), int'(exp_err));
    endtask

    // one clock edge of the reference: ALU first, else the oldest pending load
    task automatic model_edge();
        bit full;
        bit hs;
        int head;
        full = q.size() == LQ;
        hs = bus.ld_resp_valid && !bus.alu_valid && q.size() != 0;
        head = q.size() != 0 ? q[0] : 0;
        if (bus.alu_valid) begin
            exp_rd = int'(bus.alu_rd);
            exp_wd = int'(bus.alu_data);
            exp_rw = bus.alu_rd != 0;
        end else if (hs) begin
            exp_rd = head;
            exp_wd = int'(bus.ld_resp_data);
            exp_rw = head != 0;
        end else begin
            exp_rw = 1'b0;
        end
        if (hs)
            void'(q.pop_front());
        if (bus.ld_issue) begin
            if (full && !hs)
                exp_err = 1'b1;
            else
                q.push_back(int'(bus.ld_issue_rd));
        end
    endtask

    task automatic drive(input int p_alu, input int p_iss, input int p_resp, input bit ovf_ok);
        bus.alu_valid     = int'($urandom_range(99)) < p_alu;
        bus.alu_rd        = ADDR_W'($urandom_range(0, 5));
        bus.alu_data      = DATA_W'($urandom);
        bus.ld_issue      = int'($urandom_range(99)) < p_iss && (ovf_ok || q.size() < LQ);
        bus.ld_issue_rd   = ADDR_W'($urandom_range(0, 5));
        bus.ld_resp_valid = int'($urandom_range(99)) < p_resp;
        bus.ld_resp_data  = DATA_W'($urandom);
        bus.sb_rs1        = ADDR_W'($urandom_range(0, 5));
        bus.sb_rs2        = ADDR_W'($urandom_range(0, 5));
    endtask

    task automatic step(input int p_alu, input int p_iss, input int p_resp, input bit ovf_ok);
        drive(p_alu, p_iss, p_resp, ovf_ok);
        #2;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int p_alu, input int p_iss, input int p_resp, input bit ovf_ok);
        for (int i = 0; i < n; i++)
            step(p_alu, p_iss, p_resp, ovf_ok);
    endtask

    task automatic fill();
        for (int i = 0; i < 8 && q.size() < LQ; i++)
            step(0, 100, 0, 1'b0);
        check("fill_level", q.size(), LQ);
    endtask

    task automatic mid_reset();
        bus.alu_valid = 1'b0;
        bus.ld_issue = 1'b0;
        bus.ld_resp_valid = 1'b1;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        #1;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        bus.alu_valid = 1'b0;
        bus.alu_rd = '0;
        bus.alu_data = '0;
        bus.ld_issue = 1'b0;
        bus.ld_issue_rd = '0;
        bus.ld_resp_valid = 1'b0;
        bus.ld_resp_data = '0;
        bus.sb_rs1 = '0;
        bus.sb_rs2 = '0;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;
        @(posedge clk);
        #1;
        run(400, 30, 40, 50, 1'b0);
        run(200, 70, 50, 80, 1'b0);
        fill();
        run(300, 25, 60, 40, 1'b1);
        fill();
        mid_reset();
        step(100, 0, 0, 1'b0);
        run(300, 30, 50, 50, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
